// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module   : mem_access_sequencer
// Purpose  : Control FSM sequencing the LC-3 memory-access datapath
//            (MARMux, MAR, MDR, memory) for LD/ST, LDI/STI and the TRAP
//            vector-table fetch, with a memReady wait counter and timeout.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start               - command request (sampled in IDLE only)
//            isStore/isTrap/indirect - command attributes, latched on accept
//            memReady            - memory ready handshake
//            selMAR, gateMARMux, gateMDR, ldMAR, ldMDR, selMDRMem,
//            memEn, memWE        - datapath controls
//            busy, done, error   - status (done/error are 1-cycle pulses)
// Config   : MEM_INDIRECT_EN - when defined, builds the IND state and the
//            LDI/STI sequences; otherwise indirect commands run as LD/ST.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer #(
   parameter int unsigned TIMEOUT = 16   // legal range 1..255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic isStore,
   input  logic isTrap,
   input  logic indirect,
   input  logic memReady,
   output logic selMAR,
   output logic gateMARMux,
   output logic gateMDR,
   output logic ldMAR,
   output logic ldMDR,
   output logic selMDRMem,
   output logic memEn,
   output logic memWE,
   output logic busy,
   output logic done,
   output logic error
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_ADDR  = 3'd1;
   localparam logic [2:0] c_READ  = 3'd2;
`ifdef MEM_INDIRECT_EN
   localparam logic [2:0] c_IND   = 3'd3;
   localparam logic       c_IND_EN = 1'b1;
`else
   localparam logic       c_IND_EN = 1'b0;
`endif
   localparam logic [2:0] c_WDATA = 3'd4;
   localparam logic [2:0] c_WRITE = 3'd5;
   localparam logic [2:0] c_DONE  = 3'd6;
   localparam logic [2:0] c_FAULT = 3'd7;

   // Counter value seen on the TIMEOUT-th cycle of a memory state.
   localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       trap_q, trap_d;
   logic       store_q, store_d;
   logic       ind_q, ind_d;     // indirect first-pass flag

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_IDLE;
         cnt_q   <= 8'd0;
         trap_q  <= 1'b0;
         store_q <= 1'b0;
         ind_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         store_q <= store_d;
         ind_q   <= ind_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trap_d  = trap_q;
      store_d = store_q;
      ind_d   = ind_q;
      case (state_q)
         c_IDLE: begin
            if (start) begin
               // TRAP overrides store and indirect attributes.
               trap_d  = isTrap;
               store_d = isStore & ~isTrap;
               ind_d   = indirect & ~isTrap & c_IND_EN;
               state_d = c_ADDR;
            end
         end
         c_ADDR: begin
            cnt_d = 8'd0;
            if (store_q && !ind_q) state_d = c_WDATA;
            else                   state_d = c_READ;
         end
         c_READ: begin
            if (memReady) begin
`ifdef MEM_INDIRECT_EN
               state_d = ind_q ? c_IND : c_DONE;
`else
               state_d = c_DONE;
`endif
            end else if (cnt_q == c_CNT_LAST) begin
               state_d = c_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`ifdef MEM_INDIRECT_EN
         c_IND: begin
            ind_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = store_q ? c_WDATA : c_READ;
         end
`endif
         c_WDATA: begin
            cnt_d   = 8'd0;
            state_d = c_WRITE;
         end
         c_WRITE: begin
            if (memReady) begin
               state_d = c_DONE;
            end else if (cnt_q == c_CNT_LAST) begin
               state_d = c_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         c_DONE:  state_d = c_IDLE;
         c_FAULT: state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   // Output decode from registered state plus memReady
   always_comb begin
      selMAR     = 1'b0;
      gateMARMux = 1'b0;
      gateMDR    = 1'b0;
      ldMAR      = 1'b0;
      ldMDR      = 1'b0;
      selMDRMem  = 1'b0;
      memEn      = 1'b0;
      memWE      = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      busy       = (state_q != c_IDLE);
      case (state_q)
         c_ADDR: begin
            gateMARMux = 1'b1;
            ldMAR      = 1'b1;
            selMAR     = trap_q;
         end
         c_READ: begin
            memEn     = 1'b1;
            ldMDR     = memReady;
            selMDRMem = memReady;
         end
`ifdef MEM_INDIRECT_EN
         c_IND: begin
            gateMDR = 1'b1;
            ldMAR   = 1'b1;
         end
`endif
         c_WDATA: ldMDR = 1'b1;
         c_WRITE: begin
            memEn = 1'b1;
            memWE = 1'b1;
         end
         c_DONE:  done  = 1'b1;
         c_FAULT: error = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire
